// File: rtl/scancode_pkg.sv
// scancode_pkg: FSM states, prefix codes and the PS/2 set-2 to ASCII map
package scancode_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_BREAK, ST_EXT, ST_EXT_BREAK} state_t;
  localparam logic [7:0] BRK_CODE = 8'hF0;
  localparam logic [7:0] EXT_CODE = 8'hE0;
  localparam logic [7:0] LSHIFT_CODE = 8'h12;
  localparam logic [7:0] RSHIFT_CODE = 8'h59;
  localparam logic [7:0] ASCII_SP = 8'h20;
  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_BS = 8'h08;
  localparam logic [7:0] CASE_OFS = 8'h20;
  function automatic logic [8:0] map_code(input logic [7:0] c, input logic sh);
    logic [7:0] a;
    case (c)
      8'h1C: a = "a";
      8'h32: a = "b";
      8'h21: a = "c";
      8'h23: a = "d";
      8'h24: a = "e";
      8'h2B: a = "f";
      8'h34: a = "g";
      8'h33: a = "h";
      8'h43: a = "i";
      8'h3B: a = "j";
      8'h42: a = "k";
      8'h4B: a = "l";
      8'h3A: a = "m";
      8'h31: a = "n";
      8'h44: a = "o";
      8'h4D: a = "p";
      8'h15: a = "q";
      8'h2D: a = "r";
      8'h1B: a = "s";
      8'h2C: a = "t";
      8'h3C: a = "u";
      8'h2A: a = "v";
      8'h1D: a = "w";
      8'h22: a = "x";
      8'h35: a = "y";
      8'h1A: a = "z";
      8'h45: a = "0";
      8'h16: a = "1";
      8'h1E: a = "2";
      8'h26: a = "3";
      8'h25: a = "4";
      8'h2E: a = "5";
      8'h36: a = "6";
      8'h3D: a = "7";
      8'h3E: a = "8";
      8'h46: a = "9";
      8'h29: a = ASCII_SP;
      8'h5A: a = ASCII_CR;
      8'h66: a = ASCII_BS;
      default: a = 8'h00;
    endcase
    return {a != 8'h00, (sh && a >= "a") ? a - CASE_OFS : a};
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: first-word-fall-through FIFO, push accepted when full if popping
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic wen, ren;
  assign ren = pop & ~empty;
  assign wen = push & (~full | ren);
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign dout = empty ? '0 : mem[rp];
  // pointer and occupancy bookkeeping
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      wp <= wen ? wp + AW'(1) : wp;
      rp <= ren ? rp + AW'(1) : rp;
      cnt <= cnt + (AW+1)'(wen) - (AW+1)'(ren);
    end
  // storage needs no reset; empty masks stale contents
  always_ff @(posedge clk)
    if (wen) mem[wp] <= din;
endmodule

// File: rtl/scancode_decoder.sv
// scancode_decoder: PS/2 set-2 byte stream to ASCII characters via a FIFO
module scancode_decoder
  import scancode_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr,
  input  logic [7:0] code,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       shift_active,
  output logic       overflow,
  output logic       unmapped
);
  state_t state, state_n;
  logic wr_q, acc_q, lsh, rsh, lsh_n, rsh_n, push, unm_n, full, empty, pop;
  logic [7:0] code_q;
  logic [8:0] m;
  // capture one byte per wr rising edge so a held wr decodes once
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_q <= 1'b0;
      acc_q <= 1'b0;
      code_q <= 8'h00;
    end else begin
      wr_q <= wr;
      acc_q <= wr & ~wr_q;
      code_q <= (wr & ~wr_q) ? code : code_q;
    end
  // prefix state, shift flags and one-cycle status pulses
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= ST_IDLE;
      lsh <= 1'b0;
      rsh <= 1'b0;
      overflow <= 1'b0;
      unmapped <= 1'b0;
    end else begin
      state <= state_n;
      lsh <= lsh_n;
      rsh <= rsh_n;
      overflow <= push & full & ~pop;
      unmapped <= unm_n;
    end
  assign m = map_code(code_q, lsh | rsh);
  // decode the captured byte against the current prefix state
  always_comb begin
    state_n = state;
    lsh_n = lsh;
    rsh_n = rsh;
    push = 1'b0;
    unm_n = 1'b0;
    if (acc_q)
      case (state)
        ST_IDLE: begin
          state_n = code_q == BRK_CODE ? ST_BREAK : code_q == EXT_CODE ? ST_EXT : ST_IDLE;
          lsh_n = lsh | (code_q == LSHIFT_CODE);
          rsh_n = rsh | (code_q == RSHIFT_CODE);
          push = state_n == ST_IDLE && code_q != LSHIFT_CODE && code_q != RSHIFT_CODE && m[8];
          unm_n = state_n == ST_IDLE && code_q != LSHIFT_CODE && code_q != RSHIFT_CODE && !m[8];
        end
        ST_BREAK: begin
          state_n = ST_IDLE;
          lsh_n = lsh & (code_q != LSHIFT_CODE);
          rsh_n = rsh & (code_q != RSHIFT_CODE);
        end
        ST_EXT: state_n = code_q == BRK_CODE ? ST_EXT_BREAK : ST_IDLE;
        ST_EXT_BREAK: state_n = ST_IDLE;
      endcase
  end
  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .din(m[7:0]),
    .pop(pop),
    .dout(out_data),
    .full(full),
    .empty(empty)
  );
  assign out_valid = ~empty;
  assign pop = out_valid & out_ready;
  assign shift_active = lsh | rsh;
endmodule

// File: tb/tb_scancode_decoder.sv
// tb_scancode_decoder: scoreboard bench with a sequence-level reference model
module tb_scancode_decoder;
  localparam int DEPTH = 4;
  logic clk = 1'b0, rst = 1'b1, wr = 1'b0, out_ready = 1'b1;
  logic [7:0] code = 8'h00;
  logic out_valid, shift_active, overflow, unmapped;
  logic [7:0] out_data;
  scancode_decoder #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .wr(wr), .code(code), .out_ready(out_ready),
    .out_valid(out_valid), .out_data(out_data), .shift_active(shift_active),
    .overflow(overflow), .unmapped(unmapped)
  );
  always #5 clk = ~clk;
  int checks = 0, errors = 0, exp_unm = 0, exp_ovf = 0, unm_n = 0, ovf_n = 0;
  byte unsigned exp_q[$], pend[$], lut[256];
  byte unsigned mapped[39];
  bit ls, rs, rand_rdy, held;
  logic [7:0] held_d;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk)
    if (rst) held = 1'b0;
    else begin
      if (overflow) ovf_n++;
      if (unmapped) unm_n++;
      if (held) chk("hold_stable", {out_valid, out_data}, {1'b1, held_d});
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_char: got %0h expected none", out_data);
        end else chk("char", out_data, exp_q.pop_front());
      end
      held = out_valid && !out_ready;
      held_d = out_data;
    end
  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) out_ready = $urandom_range(0, 3) != 0;
  endtask
  task automatic model(input byte unsigned b);
    byte unsigned c;
    if (pend.size() == 0) begin
      if (b == 8'hF0 || b == 8'hE0) pend.push_back(b);
      else if (b == 8'h12) ls = 1'b1;
      else if (b == 8'h59) rs = 1'b1;
      else if (lut[b] == 0) exp_unm++;
      else begin
        c = lut[b];
        if ((ls || rs) && c >= "a" && c <= "z") c = c - 32;
        if (exp_q.size() >= DEPTH && !out_ready) exp_ovf++;
        else exp_q.push_back(c);
      end
    end else if (pend.size() == 1 && pend[0] == 8'hE0 && b == 8'hF0) pend.push_back(b);
    else begin
      if (pend.size() == 1 && pend[0] == 8'hF0) begin
        if (b == 8'h12) ls = 1'b0;
        if (b == 8'h59) rs = 1'b0;
      end
      pend.delete();
    end
  endtask
  task automatic send(input byte unsigned b, input int hold);
    code = b;
    wr = 1'b1;
    model(b);
    repeat (hold) tick();
    wr = 1'b0;
    tick();
    tick();
    chk("shift_active", shift_active, int'(ls || rs));
  endtask
  task automatic settle();
    repeat (4) tick();
    chk("unmapped_count", unm_n, exp_unm);
    chk("overflow_count", ovf_n, exp_ovf);
  endtask
  task automatic drain();
    rand_rdy = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick();
    chk("drain_left", exp_q.size(), 0);
    exp_q.delete();
    repeat (3) tick();
  endtask
  initial begin
    byte unsigned lc[26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
      8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C,
      8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    byte unsigned dc[10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    byte unsigned b;
    int r;
    foreach (lut[i]) lut[i] = 0;
    foreach (lc[i]) begin lut[lc[i]] = "a" + i; mapped[i] = lc[i]; end
    foreach (dc[i]) begin lut[dc[i]] = "0" + i; mapped[26 + i] = dc[i]; end
    lut[8'h29] = 8'h20; lut[8'h5A] = 8'h0D; lut[8'h66] = 8'h08;
    mapped[36] = 8'h29; mapped[37] = 8'h5A; mapped[38] = 8'h66;
    repeat (3) tick();
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_shift", shift_active, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_unmapped", unmapped, 0);
    rst = 1'b0;
    tick();
    send(8'h1C, 1); send(8'hF0, 1); send(8'h1C, 2);
    settle(); drain();
    send(8'h12, 1); send(8'h42, 1); send(8'hF0, 1); send(8'h12, 1); send(8'h42, 1);
    settle(); drain();
    code = 8'h29; wr = 1'b1; model(8'h29);
    repeat (20) tick();
    wr = 1'b0;
    settle(); drain();
    out_ready = 1'b0;
    send(8'h16, 2); send(8'h1E, 2); send(8'h26, 2); send(8'h25, 2); send(8'h2E, 2);
    settle();
    chk("full_valid", out_valid, 1);
    drain();
    send(8'hE0, 1); send(8'h75, 1); send(8'hE0, 1); send(8'hF0, 1); send(8'h75, 1);
    settle();
    chk("ext_no_output", out_valid, 0);
    send(8'h05, 1);
    settle();
    chk("unmapped_no_output", out_valid, 0);
    out_ready = 1'b0;
    send(8'h59, 1); send(8'h1C, 1); send(8'h32, 1); send(8'hF0, 1);
    chk("queued_valid", out_valid, 1);
    rst = 1'b1;
    tick();
    exp_q.delete(); pend.delete(); ls = 1'b0; rs = 1'b0;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_shift", shift_active, 0);
    rst = 1'b0;
    tick();
    out_ready = 1'b1;
    send(8'h1C, 1);
    settle(); drain();
    rand_rdy = 1'b1;
    repeat (300) begin
      for (int i = 0; i < 200 && exp_q.size() >= DEPTH; i++) tick();
      r = $urandom_range(0, 9);
      b = r < 5 ? mapped[$urandom_range(0, 38)] : r == 5 ? 8'hF0 : r == 6 ? 8'hE0 :
          r == 7 ? 8'h12 : r == 8 ? 8'h59 : 8'($urandom_range(0, 255));
      send(b, $urandom_range(1, 3));
    end
    settle(); drain();
    repeat (5) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/scancode_decoder.md
SCANCODE_DECODER -- requirements
Module: scancode_decoder

Interface
REQ-001 SHALL have parameter: FIFO_DEPTH, 4, output character FIFO depth (power of two, >= 2).
REQ-002 SHALL have port: clk  in  1  clock; all state changes on rising edge.
REQ-003 SHALL have port: rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: wr  in  1  byte-write request from the scan-code source (level; may be held for many cycles).
REQ-005 SHALL have port: code  in  8  PS/2 set-2 scan-code byte, sampled when a wr rising edge is detected.
REQ-006 SHALL have port: out_ready  in  1  LCD-side consumer ready.
REQ-007 SHALL have port: out_valid  out  1  FIFO head holds a character.
REQ-008 SHALL have port: out_data  out  8  ASCII character at FIFO head (first-word-fall-through).
REQ-009 SHALL have port: shift_active  out  1  a shift key is currently held.
REQ-010 SHALL have port: overflow  out  1  one-cycle pulse when a decoded character is dropped because the FIFO is full.
REQ-011 SHALL have port: unmapped  out  1  one-cycle pulse when a make code outside the map is received in IDLE.

Function
REQ-012 SHALL register wr into wr_q and accept exactly one byte per cycle where wr=1 and wr_q=0; held wr SHALL NOT repeat the byte.
REQ-013 SHALL run the FSM states IDLE, BREAK, EXT, EXT_BREAK, advancing only on accepted bytes.
REQ-014 IDLE: F0 -> BREAK; E0 -> EXT; 12 or 59 -> set shift, stay; mapped code -> push ASCII, stay; other -> unmapped pulse, stay.
REQ-015 BREAK: any byte -> IDLE; 12 or 59 clears shift; all other bytes discarded with no output.
REQ-016 EXT: F0 -> EXT_BREAK; any other byte discarded -> IDLE. EXT_BREAK: any byte discarded -> IDLE. No unmapped pulse in EXT/EXT_BREAK.
REQ-017 Map, set 2: letters (1C=a, 32=b, 21=c, 23=d, 24=e, 2B=f, 34=g, 33=h, 43=i, 3B=j, 42=k, 4B=l, 3A=m, 31=n, 44=o, 4D=p, 15=q, 2D=r, 1B=s, 2C=t, 3C=u, 2A=v, 1D=w, 22=x, 35=y, 1A=z) are lowercase and uppercase when shift_active=1.
REQ-018 Map, unaffected by shift: digits 45,16,1E,26,25,2E,36,3D,3E,46 = '0'..'9'; 29=0x20; 5A=0x0D; 66=0x08.
REQ-019 Repeated make codes without a break (typematic) SHALL each push a character.
REQ-020 Latency: a character from a byte accepted at edge N SHALL be on out_data with out_valid=1 after edge N+1 if the FIFO was empty.
REQ-021 Pop SHALL occur on an edge where out_valid=1 and out_ready=1; out_data SHALL stay stable while out_valid=1 and out_ready=0.
REQ-022 Push when full without a same-cycle pop SHALL drop the character and pulse overflow. Push and pop in the same cycle when full SHALL accept the push.
REQ-023 FIFO pointers SHALL wrap modulo FIFO_DEPTH, with an occupancy count of width log2(FIFO_DEPTH)+1. Order SHALL be strictly FIFO.
REQ-024 shift_active SHALL be the OR of left (12) and right (59) shift flags, each tracked separately.

Reset
REQ-025 On rst: state=IDLE, wr_q=0, both shift flags=0, FIFO empty, out_valid=0, out_data=0x00, overflow=0, unmapped=0.
REQ-026 rst mid-operation SHALL discard pending characters and partial prefix sequences. The first accepted byte after release SHALL be decoded from IDLE.

Structure
REQ-027 Package scancode_pkg SHALL hold the FSM state encoding, prefix constants (F0, E0, 12, 59), control ASCII constants, and the code-to-ASCII map function.
REQ-028 The FIFO SHALL be a sub-module sync_fifo (width 8, depth FIFO_DEPTH, FWFT, full/empty outputs). The FSM and map SHALL live in scancode_decoder.

Verification
REQ-029 Scenario 1: out_ready=1; bytes 1C, F0, 1C -> single output 0x61; no unmapped pulse.
REQ-030 Scenario 2: bytes 12, 42, F0, 12, 42 -> outputs 0x4B then 0x6B; shift_active high from the 12 make to the F0 12 break.
REQ-031 Scenario 3: wr held high 20 cycles with code=29 -> exactly one 0x20 output.
REQ-032 Scenario 4: out_ready=0; push 16, 1E, 26, 25, 2E (depth 4) -> overflow pulse on the fifth byte; drain yields 0x31, 0x32, 0x33, 0x34.
REQ-033 Scenario 5: bytes E0, 75, E0, F0, 75 -> no output and no unmapped pulse; then byte 05 -> unmapped pulse, no output.
REQ-034 Scenario 6: two characters queued, FSM in BREAK, rst pulsed -> out_valid=0 and shift_active=0; then byte 1C -> output 0x61.
